// File: rtl/prng_arbiter.sv
// prng_arbiter
//   Shares a single Trivium PRNG between NUM_REQ client sequencers. Accepts a
//   256-bit seed, pulses reseed into the PRNG, then hands out 128-bit blocks to
//   one client at a time. A fresh seed is demanded after MAX_BLOCKS blocks or
//   when force_reseed is pulsed.
//
// Build option:
//   PRNG_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest client index wins
//                           undefined -> round-robin (default)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   seed_in/_valid    seed from seed source; seed_ready accepts it
//   force_reseed      one-cycle demand for a reseed at the next arbitration point
//   need_seed         high while waiting for a seed
//   seed, reseed      registered seed and one-cycle reseed pulse to the PRNG
//   rdi_data/_valid   PRNG block stream; rdi_ready consumes a block
//   cl_req            per-client level request
//   cl_grant          registered one-hot grant, held through FETCH and DELIVER
//   cl_data           last delivered block, shared by all clients
//   cl_valid          one-hot one-cycle delivery strobe
//   blocks_left       blocks remaining before a reseed is mandatory
module prng_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BLOCKS = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [255:0]       seed_in,
   input  logic               seed_valid,
   output logic               seed_ready,
   input  logic               force_reseed,
   output logic               need_seed,
   output logic [255:0]       seed,
   output logic               reseed,
   input  logic [127:0]       rdi_data,
   input  logic               rdi_valid,
   output logic               rdi_ready,
   input  logic [NUM_REQ-1:0] cl_req,
   output logic [NUM_REQ-1:0] cl_grant,
   output logic [127:0]       cl_data,
   output logic [NUM_REQ-1:0] cl_valid,
   output logic [15:0]        blocks_left
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SumW = IdxW + 1;

   typedef enum logic [2:0] {
      StSeedWait,
      StReseed,
      StArb,
      StFetch,
      StDeliver
   } state_e;

   state_e               state_q, state_d;
   logic [255:0]         seed_q;
   logic [127:0]         data_q;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [15:0]          blocks_q, blocks_d;
   logic                 pend_q, pend_d;

   logic                 seed_load;
   logic                 data_load;
   logic                 grant_take;
   logic                 any_req;
   logic [IdxW-1:0]      win_idx;

   assign any_req = |cl_req;

   // ------------------------------------------------------------------------
   // Winner selection
   // ------------------------------------------------------------------------
`ifdef PRNG_ARB_FIXED_PRIO_EN
   // Scan from the top so the lowest requesting index is the last to write.
   always_comb begin
      win_idx = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (cl_req[j]) win_idx = IdxW'(j);
      end
   end
`else
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0] req_rot;
   logic [SumW-1:0]    off;
   logic [SumW-1:0]    sum;

   // Rotate requests so bit 0 is the pointer position, find the first set bit,
   // then map the offset back to an absolute client index.
   always_comb begin
      req_rot = NUM_REQ'({cl_req, cl_req} >> ptr_q);
      off     = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_rot[j]) off = SumW'(j);
      end
      sum = {1'b0, ptr_q} + off;
      if (sum >= SumW'(NUM_REQ)) sum = sum - SumW'(NUM_REQ);
      win_idx = sum[IdxW-1:0];

      if (win_idx == IdxW'(NUM_REQ - 1)) ptr_d = '0;
      else                               ptr_d = win_idx + IdxW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)             ptr_q <= '0;
      else if (grant_take) ptr_q <= ptr_d;
   end
`endif

   // ------------------------------------------------------------------------
   // FSM next-state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_take = 1'b0;
      seed_load  = 1'b0;
      data_load  = 1'b0;

      unique case (state_q)
         StSeedWait: begin
            if (seed_valid) begin
               seed_load = 1'b1;
               state_d   = StReseed;
            end
         end
         StReseed: begin
            state_d = StArb;
         end
         StArb: begin
            if (pend_q || (blocks_q == 16'd0)) begin
               state_d = StSeedWait;
            end else if (any_req) begin
               grant_take = 1'b1;
               grant_d    = NUM_REQ'(1) << win_idx;
               state_d    = StFetch;
            end
         end
         StFetch: begin
            // A client dropping its request here does not abort the transfer.
            if (rdi_valid) begin
               data_load = 1'b1;
               state_d   = StDeliver;
            end
         end
         StDeliver: begin
            grant_d = '0;
            state_d = StArb;
         end
         default: begin
            grant_d = '0;
            state_d = StSeedWait;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Block budget and pending reseed
   // ------------------------------------------------------------------------
   always_comb begin
      blocks_d = blocks_q;
      if (seed_load) begin
         blocks_d = 16'(MAX_BLOCKS);
      end else if (data_load && (blocks_q != 16'd0)) begin
         blocks_d = blocks_q - 16'd1;
      end
   end

   // A force_reseed arriving in the same cycle as a seed handshake is
   // satisfied by that very seed, so the clear takes precedence.
   always_comb begin
      pend_d = pend_q;
      if (seed_load)         pend_d = 1'b0;
      else if (force_reseed) pend_d = 1'b1;
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StSeedWait;
         seed_q   <= '0;
         data_q   <= '0;
         grant_q  <= '0;
         blocks_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         blocks_q <= blocks_d;
         pend_q   <= pend_d;
         if (seed_load) seed_q <= seed_in;
         if (data_load) data_q <= rdi_data;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: registers or decodes of the state register only
   // ------------------------------------------------------------------------
   assign seed_ready  = (state_q == StSeedWait);
   assign need_seed   = (state_q == StSeedWait);
   assign reseed      = (state_q == StReseed);
   assign rdi_ready   = (state_q == StFetch);
   assign seed        = seed_q;
   assign cl_grant    = grant_q;
   assign cl_data     = data_q;
   assign cl_valid    = (state_q == StDeliver) ? grant_q : '0;
   assign blocks_left = blocks_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter: a vector table of arbitration rounds plus
// hand-written sequences for reseed, forced reseed, reset and block exhaustion.
module tb_prng_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] seed_in;
   logic         seed_valid;
   logic         force_reseed;
   logic [127:0] rdi_data;
   logic         rdi_valid;
   logic [3:0]   cl_req;

   logic         seed_ready, need_seed, reseed, rdi_ready;
   logic [255:0] seed;
   logic [3:0]   cl_grant, cl_valid;
   logic [127:0] cl_data;
   logic [15:0]  blocks_left;

   logic         d2_seed_ready, d2_need_seed, d2_reseed, d2_rdi_ready;
   logic [255:0] d2_seed;
   logic [3:0]   d2_cl_grant, d2_cl_valid;
   logic [127:0] d2_cl_data;
   logic [15:0]  d2_blocks_left;

   prng_arbiter #(.NUM_REQ(4), .MAX_BLOCKS(1024)) dut (
      .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
      .seed_ready(seed_ready), .force_reseed(force_reseed), .need_seed(need_seed),
      .seed(seed), .reseed(reseed), .rdi_data(rdi_data), .rdi_valid(rdi_valid),
      .rdi_ready(rdi_ready), .cl_req(cl_req), .cl_grant(cl_grant), .cl_data(cl_data),
      .cl_valid(cl_valid), .blocks_left(blocks_left)
   );

   prng_arbiter #(.NUM_REQ(4), .MAX_BLOCKS(2)) dut2 (
      .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid),
      .seed_ready(d2_seed_ready), .force_reseed(force_reseed), .need_seed(d2_need_seed),
      .seed(d2_seed), .reseed(d2_reseed), .rdi_data(rdi_data), .rdi_valid(rdi_valid),
      .rdi_ready(d2_rdi_ready), .cl_req(cl_req), .cl_grant(d2_cl_grant),
      .cl_data(d2_cl_data), .cl_valid(d2_cl_valid), .blocks_left(d2_blocks_left)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_seed", seed, 256'd0);
      check("rst_reseed", {255'd0, reseed}, 256'd0);
      check("rst_seed_ready", {255'd0, seed_ready}, 256'd1);
      check("rst_need_seed", {255'd0, need_seed}, 256'd1);
      check("rst_rdi_ready", {255'd0, rdi_ready}, 256'd0);
      check("rst_cl_grant", {252'd0, cl_grant}, 256'd0);
      check("rst_cl_valid", {252'd0, cl_valid}, 256'd0);
      check("rst_cl_data", {128'd0, cl_data}, 256'd0);
      check("rst_blocks_left", {240'd0, blocks_left}, 256'd0);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  grant;
      logic [15:0] bl;
   } vec_t;

   vec_t          tbl [13];
   logic [255:0]  seed_a;
   logic [255:0]  seed_b;
   int            n_val;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      seed_a = {4{64'h0123456789ABCDEF}};
      seed_b = {8{32'h5A5A1234}};

      // Round-robin trace: 0100 wins 2 (ptr->3), then 1111 gives 3,0,1,2,3,0,1,2
      // (ptr->3), 1010 gives 3 then 1, 0001 gives 0, 0110 gives 1.
`ifdef PRNG_ARB_FIXED_PRIO_EN
      tbl[0] = '{4'b0100, 4'b0100, 16'd1023};
      for (int i = 1; i <= 8; i++) tbl[i] = '{4'b1111, 4'b0001, 16'(1023 - i)};
      tbl[9]  = '{4'b1010, 4'b0010, 16'd1014};
      tbl[10] = '{4'b1010, 4'b0010, 16'd1013};
      tbl[11] = '{4'b0001, 4'b0001, 16'd1012};
      tbl[12] = '{4'b0110, 4'b0010, 16'd1011};
`else
      tbl[0]  = '{4'b0100, 4'b0100, 16'd1023};
      tbl[1]  = '{4'b1111, 4'b1000, 16'd1022};
      tbl[2]  = '{4'b1111, 4'b0001, 16'd1021};
      tbl[3]  = '{4'b1111, 4'b0010, 16'd1020};
      tbl[4]  = '{4'b1111, 4'b0100, 16'd1019};
      tbl[5]  = '{4'b1111, 4'b1000, 16'd1018};
      tbl[6]  = '{4'b1111, 4'b0001, 16'd1017};
      tbl[7]  = '{4'b1111, 4'b0010, 16'd1016};
      tbl[8]  = '{4'b1111, 4'b0100, 16'd1015};
      tbl[9]  = '{4'b1010, 4'b1000, 16'd1014};
      tbl[10] = '{4'b1010, 4'b0010, 16'd1013};
      tbl[11] = '{4'b0001, 4'b0001, 16'd1012};
      tbl[12] = '{4'b0110, 4'b0010, 16'd1011};
`endif

      rst          = 1'b1;
      seed_in      = '0;
      seed_valid   = 1'b0;
      force_reseed = 1'b0;
      rdi_data     = '0;
      rdi_valid    = 1'b0;
      cl_req       = '0;
      step();
      step();
      check_reset_values();

      // Seed handshake
      rst        = 1'b0;
      seed_in    = seed_a;
      seed_valid = 1'b1;
      step();
      seed_valid = 1'b0;
      check("seed_latched", seed, seed_a);
      check("reseed_pulse", {255'd0, reseed}, 256'd1);
      check("blocks_init", {240'd0, blocks_left}, 256'd1024);
      check("need_seed_low", {255'd0, need_seed}, 256'd0);
      step();
      check("reseed_one_cycle", {255'd0, reseed}, 256'd0);

      // Arbitration table: one full ARB->FETCH->DELIVER round per entry
      for (int i = 0; i < 13; i++) begin
         rdi_data  = {4{32'hC0DE0000 | 32'(i)}};
         rdi_valid = 1'b1;
         cl_req    = tbl[i].req;
         step();
         check($sformatf("grant[%0d]", i), {252'd0, cl_grant}, {252'd0, tbl[i].grant});
         check($sformatf("rdi_ready[%0d]", i), {255'd0, rdi_ready}, 256'd1);
         step();
         check($sformatf("cl_valid[%0d]", i), {252'd0, cl_valid}, {252'd0, tbl[i].grant});
         check($sformatf("cl_data[%0d]", i), {128'd0, cl_data},
               {128'd0, {4{32'hC0DE0000 | 32'(i)}}});
         check($sformatf("blocks_left[%0d]", i), {240'd0, blocks_left}, {240'd0, tbl[i].bl});
         step();
         check($sformatf("grant_clear[%0d]", i), {252'd0, cl_grant}, 256'd0);
      end

      // Idle ARB with a stray seed_valid: nothing granted, seed unchanged
      cl_req     = '0;
      rdi_valid  = 1'b0;
      seed_in    = '1;
      seed_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("idle_grant", {252'd0, cl_grant}, 256'd0);
         check("idle_seed_kept", seed, seed_a);
      end
      seed_valid = 1'b0;

      // force_reseed mid-FETCH with the block delayed; client drops its request
      cl_req = 4'b0001;
      step();
      check("fr_grant", {252'd0, cl_grant}, 256'd1);
      cl_req       = '0;
      force_reseed = 1'b1;
      step();
      force_reseed = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("fr_wait_no_valid", {252'd0, cl_valid}, 256'd0);
      end
      rdi_data  = {2{64'hFEEDFACE12345678}};
      rdi_valid = 1'b1;
      step();
      rdi_valid = 1'b0;
      check("fr_delivered", {252'd0, cl_valid}, 256'd1);
      check("fr_data", {128'd0, cl_data}, {128'd0, {2{64'hFEEDFACE12345678}}});
      check("fr_blocks", {240'd0, blocks_left}, 256'd1010);
      cl_req = 4'b1111;
      step();
      check("fr_arb_need_seed", {255'd0, need_seed}, 256'd0);
      step();
      check("fr_seed_wait", {255'd0, need_seed}, 256'd1);
      step();
      check("fr_no_grant", {252'd0, cl_grant}, 256'd0);
      check("fr_still_waiting", {255'd0, seed_ready}, 256'd1);

      // Reset during FETCH
      cl_req     = '0;
      seed_in    = seed_b;
      seed_valid = 1'b1;
      step();
      seed_valid = 1'b0;
      check("rs_reseed", {255'd0, reseed}, 256'd1);
      step();
      cl_req = 4'b0010;
      step();
      check("rs_grant", {252'd0, cl_grant}, 256'd2);
      rst       = 1'b1;
      rdi_valid = 1'b1;
      step();
      check_reset_values();
      rst        = 1'b0;
      seed_in    = seed_a;
      seed_valid = 1'b1;
      cl_req     = 4'b1111;
      rdi_data   = {4{32'h600DF00D}};
      step();
      seed_valid = 1'b0;
      check("rs_seed_accepted", seed, seed_a);
      check("rs_reseed2", {255'd0, reseed}, 256'd1);
      step();
      step();
      check("rs_ptr_reset_grant", {252'd0, cl_grant}, 256'd1);
      step();
      check("rs_deliver", {252'd0, cl_valid}, 256'd1);
      check("rs_blocks", {240'd0, blocks_left}, 256'd1023);

      // Block exhaustion on the MAX_BLOCKS=2 instance
      rst    = 1'b1;
      cl_req = '0;
      step();
      rst        = 1'b0;
      seed_in    = seed_b;
      seed_valid = 1'b1;
      step();
      seed_valid = 1'b0;
      check("ex_reseed", {255'd0, d2_reseed}, 256'd1);
      check("ex_blocks_init", {240'd0, d2_blocks_left}, 256'd2);
      cl_req    = 4'b0001;
      rdi_valid = 1'b1;
      n_val     = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         if (d2_cl_valid != 4'd0) n_val++;
      end
      check("ex_deliveries", 256'(n_val), 256'd2);
      check("ex_need_seed", {255'd0, d2_need_seed}, 256'd1);
      check("ex_no_grant", {252'd0, d2_cl_grant}, 256'd0);
      check("ex_blocks_zero", {240'd0, d2_blocks_left}, 256'd0);
      seed_valid = 1'b1;
      step();
      seed_valid = 1'b0;
      check("ex_reseed2", {255'd0, d2_reseed}, 256'd1);
      check("ex_blocks_reload", {240'd0, d2_blocks_left}, 256'd2);
      step();
      step();
      check("ex_grant_resume", {252'd0, d2_cl_grant}, 256'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
